baud_cfg_ctrl: RTL

//  Run-time baud configuration controller and tick generator for the UART.

---
 rtl/baud_cfg_ctrl_pkg.sv | 58 +++++
 rtl/baud_cfg_ctrl_if.sv | 24 ++
 rtl/baud_div_lut.sv | 13 +
 rtl/baud_cfg_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/baud_cfg_ctrl_pkg.sv
// Shared constants for the UART baud configuration controller: baud codes,
// the 100 MHz bit-period table and the controller FSM encoding.
package baud_cfg_ctrl_pkg;

   localparam int CODE_W = 4;
   localparam int DIV_W  = 19;

   localparam logic [CODE_W-1:0] BAUD_300     = 4'd0;
   localparam logic [CODE_W-1:0] BAUD_1200    = 4'd1;
   localparam logic [CODE_W-1:0] BAUD_2400    = 4'd2;
   localparam logic [CODE_W-1:0] BAUD_4800    = 4'd3;
   localparam logic [CODE_W-1:0] BAUD_9600    = 4'd4;
   localparam logic [CODE_W-1:0] BAUD_19200   = 4'd5;
   localparam logic [CODE_W-1:0] BAUD_38400   = 4'd6;
   localparam logic [CODE_W-1:0] BAUD_57600   = 4'd7;
   localparam logic [CODE_W-1:0] BAUD_115200  = 4'd8;
   localparam logic [CODE_W-1:0] BAUD_230400  = 4'd9;
   localparam logic [CODE_W-1:0] BAUD_460800  = 4'd10;
   localparam logic [CODE_W-1:0] BAUD_921600  = 4'd11;
   localparam logic [CODE_W-1:0] BAUD_DEFAULT = BAUD_9600;

   localparam logic [DIV_W-1:0] DIV_300     = 19'd333333;
   localparam logic [DIV_W-1:0] DIV_1200    = 19'd83333;
   localparam logic [DIV_W-1:0] DIV_2400    = 19'd41667;
   localparam logic [DIV_W-1:0] DIV_4800    = 19'd20833;
   localparam logic [DIV_W-1:0] DIV_9600    = 19'd10417;
   localparam logic [DIV_W-1:0] DIV_19200   = 19'd5208;
   localparam logic [DIV_W-1:0] DIV_38400   = 19'd2604;
   localparam logic [DIV_W-1:0] DIV_57600   = 19'd1736;
   localparam logic [DIV_W-1:0] DIV_115200  = 19'd868;
   localparam logic [DIV_W-1:0] DIV_230400  = 19'd434;
   localparam logic [DIV_W-1:0] DIV_460800  = 19'd217;
   localparam logic [DIV_W-1:0] DIV_921600  = 19'd109;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   // Unused codes fall back to 9600 baud so a bad request never stalls the link.
   function automatic logic [DIV_W-1:0] baud_divisor(input logic [CODE_W-1:0] code);
      case (code)
         BAUD_300:    return DIV_300;
         BAUD_1200:   return DIV_1200;
         BAUD_2400:   return DIV_2400;
         BAUD_4800:   return DIV_4800;
         BAUD_9600:   return DIV_9600;
         BAUD_19200:  return DIV_19200;
         BAUD_38400:  return DIV_38400;
         BAUD_57600:  return DIV_57600;
         BAUD_115200: return DIV_115200;
         BAUD_230400: return DIV_230400;
         BAUD_460800: return DIV_460800;
         BAUD_921600: return DIV_921600;
         default:     return DIV_9600;
      endcase
   endfunction

endpackage

// File: rtl/baud_cfg_ctrl_if.sv
// Host-side configuration bus of the baud controller: request/code in,
// busy/ack/err status and the active code/divisor out.
interface baud_cfg_ctrl_if;
   import baud_cfg_ctrl_pkg::*;

   logic              cfg_req;
   logic [CODE_W-1:0] cfg_code;
   logic              cfg_busy;
   logic              cfg_ack;
   logic              cfg_err;
   logic [CODE_W-1:0] cur_code;
   logic [DIV_W-1:0]  divisor;

   modport master (
      output cfg_req, cfg_code,
      input  cfg_busy, cfg_ack, cfg_err, cur_code, divisor
   );

   modport slave (
      input  cfg_req, cfg_code,
      output cfg_busy, cfg_ack, cfg_err, cur_code, divisor
   );

endinterface

// File: rtl/baud_div_lut.sv
// Combinational map from a 4-bit baud code to the 19-bit bit period in clk cycles.
module baud_div_lut
   import baud_cfg_ctrl_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic [DIV_W-1:0]  divisor
);

   always_comb begin
      divisor = baud_divisor(code);
   end

endmodule

// File: rtl/baud_cfg_ctrl.sv
// Run-time baud configuration controller: drains TX/RX before switching the
// divisor, then restarts the bit and 16x oversample tick counters.
module baud_cfg_ctrl
   import baud_cfg_ctrl_pkg::*;
#(
   parameter logic [CODE_W-1:0] RESET_CODE = BAUD_DEFAULT,
   parameter int                OS_SHIFT   = 4,
   parameter int                DRAIN_TMO  = 1_000_000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          tick_en,
   input  logic          tx_busy,
   input  logic          rx_busy,
   output logic          bit_tick,
   output logic          os_tick,
   baud_cfg_ctrl_if.slave cfg
);

   localparam int                TMO_W     = (DRAIN_TMO > 1) ? $clog2(DRAIN_TMO) : 1;
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(DRAIN_TMO - 1);
   localparam logic [DIV_W-1:0]  RESET_DIV = baud_divisor(RESET_CODE);

   logic [1:0]        state;
   logic [CODE_W-1:0] pend_code;
   logic [CODE_W-1:0] cur_code;
   logic              force_apply;
   logic [TMO_W-1:0]  tmo;
   logic [DIV_W-1:0]  divisor;
   logic [DIV_W-1:0]  lut_div;
   logic [DIV_W-1:0]  bit_cnt;
   logic [DIV_W-1:0]  os_cnt;
   logic [DIV_W-1:0]  bit_last;
   logic [DIV_W-1:0]  os_last;
   logic              ack;
   logic              err;

   baud_div_lut u_lut (
      .code    (pend_code),
      .divisor (lut_div)
   );

   assign bit_last = divisor - DIV_W'(1);
   assign os_last  = (divisor >> OS_SHIFT) - DIV_W'(1);

   // NOTE: every register below is written with <= so all of them see the
   // pre-edge values of each other, exactly like the flops they become.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= ST_RUN;
         pend_code   <= RESET_CODE;
         cur_code    <= RESET_CODE;
         divisor     <= RESET_DIV;
         force_apply <= 1'b0;
         tmo         <= '0;
         ack         <= 1'b0;
         err         <= 1'b0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            ST_RUN: begin
               if (cfg.cfg_req) begin
                  pend_code   <= cfg.cfg_code;
                  force_apply <= 1'b0;
                  tmo         <= '0;
                  state       <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // An idle link wins over a simultaneous timeout: that apply is clean.
               if (!tx_busy && !rx_busy) begin
                  force_apply <= 1'b0;
                  state       <= ST_LOAD;
               end else if (tmo == TMO_LAST) begin
                  force_apply <= 1'b1;
                  state       <= ST_LOAD;
               end else begin
                  tmo <= tmo + TMO_W'(1);
               end
            end
            ST_LOAD: begin
               divisor  <= lut_div;
               cur_code <= pend_code;
               tmo      <= '0;
               ack      <= 1'b1;
               err      <= force_apply;
               state    <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   // Ticks keep the old divisor until LOAD, which restarts both counters from 0.
   always_ff @(posedge clk) begin
      if (!rst || !tick_en) begin
         bit_cnt  <= '0;
         os_cnt   <= '0;
         bit_tick <= 1'b0;
         os_tick  <= 1'b0;
      end else begin
         bit_tick <= (bit_cnt == bit_last);
         os_tick  <= (os_cnt == os_last);
         if (state == ST_LOAD) begin
            bit_cnt <= '0;
            os_cnt  <= '0;
         end else begin
            bit_cnt <= (bit_cnt == bit_last) ? '0 : bit_cnt + DIV_W'(1);
            os_cnt  <= (os_cnt == os_last)   ? '0 : os_cnt + DIV_W'(1);
         end
      end
   end

   assign cfg.cfg_busy = (state != ST_RUN);
   assign cfg.cfg_ack  = ack;
   assign cfg.cfg_err  = err;
   assign cfg.cur_code = cur_code;
   assign cfg.divisor  = divisor;

endmodule
